// File: rtl/track_overlay_pkg.sv
// Shared tracker/overlay types: active video geometry, coordinate and pixel types.
package track_pkg;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef logic [9:0]  coord_t;
  typedef logic [23:0] rgb_t;
endpackage

// File: rtl/track_overlay_if.sv
// Point-update and pixel-stream bundle between Tracker, overlay and VGA output.
interface track_overlay_if;
  import track_pkg::*;

  coord_t i_pointH;
  coord_t i_pointV;
  logic   i_point_valid;
  rgb_t   i_RGB;
  logic   i_pixelVAL;
  coord_t i_H;
  coord_t i_V;
  rgb_t   o_RGB;
  logic   o_pixelVAL;
  coord_t o_H;
  coord_t o_V;
  logic   o_locked;

  modport slave (
    input  i_pointH, i_pointV, i_point_valid, i_RGB, i_pixelVAL, i_H, i_V,
    output o_RGB, o_pixelVAL, o_H, o_V, o_locked
  );

  modport master (
    output i_pointH, i_pointV, i_point_valid, i_RGB, i_pixelVAL, i_H, i_V,
    input  o_RGB, o_pixelVAL, o_H, o_V, o_locked
  );
endinterface

// File: rtl/track_overlay_hit.sv
// Combinational crosshair membership test of a pixel against the active point.
module crosshair_hit
  import track_pkg::*;
#(
  parameter int ARM    = 8,
  parameter int HALF_W = 1
) (
  input  coord_t i_H,
  input  coord_t i_V,
  input  coord_t activeH,
  input  coord_t activeV,
  input  logic   locked,
  output logic   hit
);

  logic signed [10:0] dH;
  logic signed [10:0] dV;
  logic        [10:0] absH;
  logic        [10:0] absV;
  logic               horzArm;
  logic               vertArm;

  assign dH = $signed({1'b0, i_H}) - $signed({1'b0, activeH});
  assign dV = $signed({1'b0, i_V}) - $signed({1'b0, activeV});

  // Coordinates are 10-bit so differences never reach -1024; negation cannot overflow.
  assign absH = dH[10] ? $unsigned(-dH) : $unsigned(dH);
  assign absV = dV[10] ? $unsigned(-dV) : $unsigned(dV);

  assign horzArm = (absH <= 11'(ARM)) && (absV <= 11'(HALF_W));
  assign vertArm = (absV <= 11'(ARM)) && (absH <= 11'(HALF_W));
  assign hit     = locked && (horzArm || vertArm);

endmodule

// File: rtl/track_overlay.sv
// Crosshair overlay: tear-free point commit at frame start, loss timeout, 1-cycle pixel pipe.
module track_overlay
  import track_pkg::*;
#(
  parameter int   ARM         = 8,
  parameter int   HALF_W      = 1,
  parameter int   LOST_FRAMES = 4,
  parameter rgb_t MARK_RGB    = 24'hFF0000
) (
  input logic         i_clk,
  input logic         i_rst_n,
  track_overlay_if.slave px
);

  coord_t     pendH, pendV, pendHNext, pendVNext;
  logic       pendFlag, pendFlagNext;
  coord_t     activeH, activeV, activeHNext, activeVNext;
  logic [3:0] missCnt, missNext;
  logic       locked, lockedNext;
  logic       fs;
  logic       hit;

  function automatic coord_t clampCoord(input coord_t c, input int maxC);
    return (c > coord_t'(maxC)) ? coord_t'(maxC) : c;
  endfunction

  function automatic logic [3:0] satInc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  assign fs = px.i_pixelVAL && (px.i_H == '0) && (px.i_V == '0);

  always_comb begin
    pendHNext    = pendH;
    pendVNext    = pendV;
    pendFlagNext = pendFlag;
    activeHNext  = activeH;
    activeVNext  = activeV;
    missNext     = missCnt;
    lockedNext   = locked;
    if (px.i_point_valid) begin
      pendHNext    = clampCoord(px.i_pointH, H_ACT - 1);
      pendVNext    = clampCoord(px.i_pointV, V_ACT - 1);
      pendFlagNext = 1'b1;
    end
    // Commit uses the pending value from before this cycle's strobe.
    if (fs) begin
      if (pendFlag) begin
        activeHNext = pendH;
        activeVNext = pendV;
        missNext    = '0;
        lockedNext  = 1'b1;
        if (!px.i_point_valid) pendFlagNext = 1'b0;
      end else begin
        missNext = satInc(missCnt);
        if (({1'b0, missCnt} + 5'd1) >= 5'(LOST_FRAMES)) lockedNext = 1'b0;
      end
    end
  end

  // Frame-start pixel sees the freshly committed point via the next-state values.
  crosshair_hit #(.ARM(ARM), .HALF_W(HALF_W)) uHit (
    .i_H     (px.i_H),
    .i_V     (px.i_V),
    .activeH (activeHNext),
    .activeV (activeVNext),
    .locked  (lockedNext),
    .hit     (hit)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pendH         <= '0;
      pendV         <= '0;
      pendFlag      <= 1'b0;
      activeH       <= '0;
      activeV       <= '0;
      missCnt       <= '0;
      locked        <= 1'b0;
      px.o_RGB      <= '0;
      px.o_pixelVAL <= 1'b0;
      px.o_H        <= '0;
      px.o_V        <= '0;
    end else begin
      pendH         <= pendHNext;
      pendV         <= pendVNext;
      pendFlag      <= pendFlagNext;
      activeH       <= activeHNext;
      activeV       <= activeVNext;
      missCnt       <= missNext;
      locked        <= lockedNext;
      px.o_RGB      <= (px.i_pixelVAL && hit) ? MARK_RGB : px.i_RGB;
      px.o_pixelVAL <= px.i_pixelVAL;
      px.o_H        <= px.i_H;
      px.o_V        <= px.i_V;
    end
  end

  assign px.o_locked = locked;

endmodule

// File: tb/tb_track_overlay.sv
// Directed bench for track_overlay: reset, centre/edge/corner markers, loss timeout, commit timing.
module tb_track_overlay;
  import track_pkg::*;

  localparam rgb_t GREY = 24'h808080;
  localparam rgb_t RED  = 24'hFF0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  track_overlay_if bus ();

  track_overlay dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .px      (bus)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic step(input logic vld, input int h, input int v, input rgb_t rgb,
                      input logic pv = 1'b0, input int ph = 0, input int pvv = 0);
    bus.i_pixelVAL    = vld;
    bus.i_H           = 10'(h);
    bus.i_V           = 10'(v);
    bus.i_RGB         = rgb;
    bus.i_point_valid = pv;
    bus.i_pointH      = 10'(ph);
    bus.i_pointV      = 10'(pvv);
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic red);
    step(1'b1, h, v, GREY);
    chk($sformatf("rgb_%0d_%0d", h, v), 32'(bus.o_RGB), red ? 32'(RED) : 32'(GREY));
  endtask

  task automatic strobe(input int h, input int v);
    step(1'b0, 0, 0, GREY, 1'b1, h, v);
  endtask

  initial begin
    step(1'b0, 0, 0, '0);
    // Reset held for 3 clocks with pixels flowing.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i, 5, 24'h111111);
      chk("rst_rgb", 32'(bus.o_RGB), 32'h0);
      chk("rst_vld", 32'(bus.o_pixelVAL), 32'h0);
      chk("rst_h", 32'(bus.o_H), 32'h0);
      chk("rst_v", 32'(bus.o_V), 32'h0);
      chk("rst_lock", 32'(bus.o_locked), 32'h0);
    end
    rst_n = 1'b1;
    step(1'b1, 7, 3, 24'h123456);
    chk("post_rgb", 32'(bus.o_RGB), 32'h123456);
    chk("post_h", 32'(bus.o_H), 32'd7);
    chk("post_v", 32'(bus.o_V), 32'd3);
    chk("post_vld", 32'(bus.o_pixelVAL), 32'h1);
    chk("post_lock", 32'(bus.o_locked), 32'h0);
    pix(0, 0, 1'b0);
    chk("nolock_fs", 32'(bus.o_locked), 32'h0);

    // Centre marker.
    strobe(320, 240);
    chk("strobe_lock", 32'(bus.o_locked), 32'h0);
    pix(0, 0, 1'b0);
    chk("c_lock", 32'(bus.o_locked), 32'h1);
    pix(320, 240, 1'b1);
    pix(312, 240, 1'b1);
    pix(311, 240, 1'b0);
    pix(328, 240, 1'b1);
    pix(329, 240, 1'b0);
    pix(312, 239, 1'b1);
    pix(312, 241, 1'b1);
    pix(312, 242, 1'b0);
    pix(319, 232, 1'b1);
    pix(318, 232, 1'b0);
    pix(320, 231, 1'b0);
    pix(321, 248, 1'b1);
    pix(322, 248, 1'b0);
    pix(320, 249, 1'b0);
    pix(322, 242, 1'b0);
    step(1'b0, 320, 240, GREY);
    chk("gap_rgb", 32'(bus.o_RGB), 32'(GREY));
    chk("gap_vld", 32'(bus.o_pixelVAL), 32'h0);

    // Top-left clipped marker; FS pixel itself lies on the arm.
    strobe(5, 0);
    pix(0, 0, 1'b1);
    pix(13, 0, 1'b1);
    pix(14, 0, 1'b0);
    pix(13, 1, 1'b1);
    pix(13, 2, 1'b0);
    pix(4, 8, 1'b1);
    pix(6, 8, 1'b1);
    pix(4, 9, 1'b0);
    pix(639, 479, 1'b0);
    pix(0, 479, 1'b0);
    pix(639, 0, 1'b0);

    // Clamped to the bottom-right corner.
    strobe(700, 500);
    pix(0, 0, 1'b0);
    pix(639, 479, 1'b1);
    pix(631, 479, 1'b1);
    pix(630, 479, 1'b0);
    pix(639, 471, 1'b1);
    pix(639, 470, 1'b0);
    pix(638, 478, 1'b1);
    pix(637, 478, 1'b1);
    pix(637, 477, 1'b0);

    // Loss timeout: shown for 4 frames, hidden from FS of frame 5.
    strobe(100, 100);
    for (int f = 1; f <= 4; f++) begin
      pix(0, 0, 1'b0);
      chk($sformatf("loss_lock_f%0d", f), 32'(bus.o_locked), 32'h1);
      pix(100, 100, 1'b1);
    end
    pix(0, 0, 1'b0);
    chk("loss_lock_f5", 32'(bus.o_locked), 32'h0);
    pix(100, 100, 1'b0);
    pix(108, 100, 1'b0);

    // Strobe coincident with FS: old pending commits, new one waits a frame.
    strobe(10, 10);
    step(1'b1, 0, 0, GREY, 1'b1, 50, 60);
    chk("sim_fs_rgb", 32'(bus.o_RGB), 32'(GREY));
    chk("sim_fs_lock", 32'(bus.o_locked), 32'h1);
    pix(10, 10, 1'b1);
    pix(50, 60, 1'b0);
    pix(0, 0, 1'b0);
    pix(50, 60, 1'b1);
    pix(10, 10, 1'b0);

    // Mid-frame reset drops the marker until a new strobe commits.
    rst_n = 1'b0;
    step(1'b1, 50, 61, GREY);
    chk("mid_rst_rgb", 32'(bus.o_RGB), 32'h0);
    rst_n = 1'b1;
    pix(50, 60, 1'b0);
    pix(0, 0, 1'b0);
    chk("mid_rst_lock", 32'(bus.o_locked), 32'h0);
    pix(0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
